dmem_arbiter: RTL

Two-master arbiter in front of the single-port data memory. Master 0 is the pipeline load/store unit; master 1 is the loader/debug port.
- Grants one access per cycle, round-robin or fixed-priority.
- Drives the memory's write-enable, address and write-data.
- Registers read data back to the winning master one cycle after grant.
- Rejects misaligned and out-of-range accesses with an error response.

---
 rtl/dmem_arbiter_pkg.sv | 9 +
 rtl/dmem_arbiter_rr_pick2.sv | 22 ++
 rtl/dmem_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants and address legality check for the data-memory arbiter
package dmem_arbiter_pkg;
  localparam int M0 = 0;
  localparam int M1 = 1;
  localparam int WORD_BYTES = 4;
  function automatic logic legal_addr(input logic [31:0] addr, input int depth);
    return ((addr & 32'(WORD_BYTES - 1)) == 32'd0) && ((addr / WORD_BYTES) < 32'(depth));
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin / master-0-priority picker with starvation counter for master 1
module rr_pick2 #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic [1:0] gnt
);
  localparam int W = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  logic [W-1:0] cnt;
  logic         expired;
  assign expired = prio && (cnt == W'(MAX_WAIT));
  always_comb gnt = &req ? (prio ? (expired ? 2'b10 : 2'b01) : (last ? 2'b01 : 2'b10)) : req;
  // Counts consecutive master-0 wins while master 1 is waiting; any M1 win or idle M1 clears it
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (!prio || gnt[1] || !req[1]) cnt <= '0;
    else if (gnt[0] && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants one of two masters per cycle onto the single-port data memory
// and returns a registered response (read data or error) one cycle after the grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter bit PRIO_M0  = 1'b0,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  logic [1:0]  gnt;
  logic [1:0]  req;
  logic        last, any, legal, we;
  logic [31:0] addr, wdata, rdata_nxt;
  assign req = {m1_req, m0_req} & {2{~reset}};
  rr_pick2 #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .last (last),
    .prio (PRIO_M0),
    .gnt  (gnt)
  );
  always_comb begin
    any       = |gnt;
    addr      = gnt[M1] ? m1_addr : m0_addr;
    wdata     = gnt[M1] ? m1_wdata : m0_wdata;
    we        = gnt[M1] ? m1_we : m0_we;
    legal     = legal_addr(addr, DEPTH);
    mem_we    = any && we && legal;
    mem_a     = any ? addr : '0;
    mem_wd    = any ? wdata : '0;
    rdata_nxt = legal && !we ? mem_rd : '0;
  end
  assign m0_gnt = gnt[M0];
  assign m1_gnt = gnt[M1];
  // last resets to M1 so that master 0 wins the first conflict
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
      last      <= 1'b1;
    end else begin
      m0_rvalid <= gnt[M0];
      m0_rdata  <= gnt[M0] ? rdata_nxt : '0;
      m0_err    <= gnt[M0] && !legal;
      m1_rvalid <= gnt[M1];
      m1_rdata  <= gnt[M1] ? rdata_nxt : '0;
      m1_err    <= gnt[M1] && !legal;
      if (any) last <= gnt[M1];
    end
endmodule
